// File: rtl/uart_tx_fifo_if.sv
// Interface bundling the CSR push side, transceiver handshake and FIFO status outputs.
interface uart_tx_fifo_if #(
   parameter int depth_log2 = 4
);
   logic                  push;
   logic [7:0]            push_data;
   logic                  flush;
   logic [7:0]            tx_data;
   logic                  tx_wr;
   logic                  tx_done;
   logic [depth_log2:0]   level;
   logic                  full;
   logic                  empty;
   logic                  overflow;
   logic                  tx_idle;

   modport master (
      output push, push_data, flush, tx_done,
      input  tx_data, tx_wr, level, full, empty, overflow, tx_idle
   );

   modport slave (
      input  push, push_data, flush, tx_done,
      output tx_data, tx_wr, level, full, empty, overflow, tx_idle
   );
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the transmit FIFO: synchronous write, asynchronous read.
module uart_tx_fifo_mem #(
   parameter int depth_log2 = 4
) (
   input  logic                  sys_clk,
   input  logic                  wr_en_i,
   input  logic [depth_log2-1:0] wr_addr_i,
   input  logic [7:0]            wr_data_i,
   input  logic [depth_log2-1:0] rd_addr_i,
   output logic [7:0]            rd_data_o
);
   logic [7:0] mem_q [2**depth_log2];

   always_ff @(posedge sys_clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that issues one byte per tx_wr and holds the next until tx_done; push-to-tx_wr
// takes two edges. Pushes into a full FIFO (without a same-edge pop) are dropped and set overflow.
module uart_tx_fifo #(
   parameter int depth_log2 = 4
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   uart_tx_fifo_if.slave bus
);
   localparam logic IDLE = 1'b0;
   localparam logic BUSY = 1'b1;
   localparam logic [depth_log2:0]   DEPTH_LVL = (depth_log2+1)'(1 << depth_log2);
   localparam logic [depth_log2:0]   LVL_ONE   = (depth_log2+1)'(1);
   localparam logic [depth_log2-1:0] PTR_ONE   = depth_log2'(1);

   logic                  state_q, state_d;
   logic [depth_log2-1:0] wptr_q, wptr_d;
   logic [depth_log2-1:0] rptr_q, rptr_d;
   logic [depth_log2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_wr_q, tx_wr_d;
   logic [7:0]            rd_data;
   logic                  full, empty, pop, wr_en;

   assign full  = (level_q == DEPTH_LVL);
   assign empty = (level_q == '0);
   // A same-edge pop frees a slot, so a push into a full FIFO is still accepted then.
   assign pop   = (state_q == IDLE) && !empty && !bus.flush;
   assign wr_en = bus.push && !bus.flush && (!full || pop);

   uart_tx_fifo_mem #(.depth_log2(depth_log2)) u_mem (
      .sys_clk   (sys_clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q),
      .wr_data_i (bus.push_data),
      .rd_addr_i (rptr_q),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      tx_data_d  = tx_data_q;
      tx_wr_d    = 1'b0;

      case (state_q)
         IDLE:    if (pop) state_d = BUSY;
         BUSY:    if (bus.tx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (pop) begin
         rptr_d    = rptr_q + PTR_ONE;
         tx_data_d = rd_data;
         tx_wr_d   = 1'b1;
      end
      if (wr_en) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (wr_en && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (!wr_en && pop) begin
         level_d = level_q - LVL_ONE;
      end
      if (bus.push && !bus.flush && full && !pop) begin
         overflow_d = 1'b1;
      end

      // Flush empties the queue but leaves an in-flight byte to finish via tx_done.
      if (bus.flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_wr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
         tx_wr_q    <= tx_wr_d;
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_wr    = tx_wr_q;
   assign bus.level    = level_q;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.overflow = overflow_q;
   assign bus.tx_idle  = empty && (state_q == IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model plus a transceiver responder.
module tb_uart_tx_fifo;
   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   uart_tx_fifo_if #(.depth_log2(DL)) bus();
   uart_tx_fifo #(.depth_log2(DL)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

   int tests = 0;
   int fails = 0;

   // Reference model: bytes waiting, whether one is on the wire, sticky overflow, bytes issued.
   logic [7:0] m_q[$];
   logic       m_busy = 1'b0;
   logic       m_ovf  = 1'b0;
   logic [7:0] m_sent[$];

   logic [7:0] act_sent[$];
   int         wr_double = 0;
   logic       prev_wr   = 1'b0;

   bit auto_done  = 1'b0;
   int done_delay = 1;
   int done_req   = 0;
   int done_ack   = 0;
   int done_cnt   = 0;

   always @(posedge sys_clk) begin
      #1;
      if (bus.tx_wr === 1'b1) begin
         act_sent.push_back(bus.tx_data);
         if (prev_wr) wr_double++;
      end
      prev_wr = (bus.tx_wr === 1'b1);
   end

   // Transceiver: answers tx_wr after done_delay cycles when auto_done, or on explicit request.
   always @(posedge sys_clk) begin
      #2;
      bus.tx_done = 1'b0;
      if (sys_rst) begin
         done_cnt = 0;
         done_ack = done_req;
      end else begin
         if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) bus.tx_done = 1'b1;
         end else if (done_ack != done_req) begin
            done_ack++;
            bus.tx_done = 1'b1;
         end
         if (bus.tx_wr === 1'b1 && auto_done) done_cnt = done_delay;
      end
   end

   task automatic m_step(input logic p, input logic [7:0] d, input logic f, input logic done);
      logic busy0;
      busy0 = m_busy;
      if (!f && !busy0 && m_q.size() != 0) begin
         m_sent.push_back(m_q.pop_front());
         m_busy = 1'b1;
      end
      if (f) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else if (p) begin
         if (m_q.size() < DEPTH) m_q.push_back(d);
         else m_ovf = 1'b1;
      end
      if (busy0 && done) m_busy = 1'b0;
   endtask

   task automatic cyc(input logic p, input logic [7:0] d, input logic f);
      @(negedge sys_clk);
      bus.push      = p;
      bus.push_data = d;
      bus.flush     = f;
      @(posedge sys_clk);
      m_step(p, d, f, bus.tx_done);
      #1;
      bus.push  = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst   = 1'b1;
      bus.push  = 1'b0;
      bus.flush = 1'b0;
      m_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic drain(input int max, input string name);
      int n = 0;
      while (!(m_q.size() == 0 && !m_busy) && n < max) begin
         cyc(1'b0, 8'h00, 1'b0);
         n++;
      end
      cyc(1'b0, 8'h00, 1'b0);
      tests++;
      if (n >= max) begin
         fails++;
         $display("FAIL %s_drain timed out after %0d cycles, model level %0d busy %0d", name, n, m_q.size(), m_busy);
      end
   endtask

   task automatic test_reset();
      bus.push = 1'b0; bus.push_data = 8'h00; bus.flush = 1'b0;
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      tests++; if (bus.level !== 5'd0)    begin fails++; $display("FAIL reset_level got %0d want 0", bus.level); end
      tests++; if (bus.empty !== 1'b1)    begin fails++; $display("FAIL reset_empty got %b want 1", bus.empty); end
      tests++; if (bus.full !== 1'b0)     begin fails++; $display("FAIL reset_full got %b want 0", bus.full); end
      tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
      tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
      tests++; if (bus.tx_wr !== 1'b0)    begin fails++; $display("FAIL reset_tx_wr got %b want 0", bus.tx_wr); end
      tests++; if (bus.tx_idle !== 1'b1)  begin fails++; $display("FAIL reset_tx_idle got %b want 1", bus.tx_idle); end
      sys_rst = 1'b0;
   endtask

   task automatic test_single();
      int bad = 0;
      auto_done = 1'b1; done_delay = 40;
      cyc(1'b1, 8'hA5, 1'b0);
      tests++; if (bus.tx_wr !== 1'b0) begin fails++; $display("FAIL single_early_wr got %b want 0", bus.tx_wr); end
      cyc(1'b0, 8'h00, 1'b0);
      tests++; if (bus.tx_wr !== 1'b1)    begin fails++; $display("FAIL single_wr got %b want 1", bus.tx_wr); end
      tests++; if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL single_data got %h want a5", bus.tx_data); end
      cyc(1'b0, 8'h00, 1'b0);
      tests++; if (bus.tx_wr !== 1'b0)    begin fails++; $display("FAIL single_wr_pulse got %b want 0", bus.tx_wr); end
      tests++; if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL single_data_hold got %h want a5", bus.tx_data); end
      for (int k = 0; k < 45; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         if (bus.tx_idle !== (m_q.size() == 0 && !m_busy)) bad++;
      end
      tests++; if (bad != 0)              begin fails++; $display("FAIL single_idle_track got %0d wrong cycles want 0", bad); end
      tests++; if (bus.tx_idle !== 1'b1)  begin fails++; $display("FAIL single_idle_end got %b want 1", bus.tx_idle); end
   endtask

   task automatic test_reset_mid_burst();
      int s0;
      do_reset();
      auto_done = 1'b1; done_delay = 30;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0);
      tests++; if (bus.level !== 5'd3) begin fails++; $display("FAIL rstmid_level_before got %0d want 3", bus.level); end
      s0 = act_sent.size();
      @(negedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      m_q.delete(); m_busy = 1'b0; m_ovf = 1'b0;
      tests++; if (bus.level !== 5'd0)   begin fails++; $display("FAIL rstmid_level got %0d want 0", bus.level); end
      tests++; if (bus.empty !== 1'b1)   begin fails++; $display("FAIL rstmid_empty got %b want 1", bus.empty); end
      tests++; if (bus.tx_wr !== 1'b0)   begin fails++; $display("FAIL rstmid_tx_wr got %b want 0", bus.tx_wr); end
      tests++; if (bus.tx_idle !== 1'b1) begin fails++; $display("FAIL rstmid_tx_idle got %b want 1", bus.tx_idle); end
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (10) cyc(1'b0, 8'h00, 1'b0);
      tests++; if (act_sent.size() != s0) begin fails++; $display("FAIL rstmid_no_wr got %0d bytes want %0d", act_sent.size(), s0); end
   endtask

   task automatic test_burst_wrap();
      int s0, bad = 0, guard = 0;
      do_reset();
      auto_done = 1'b1; done_delay = 10;
      s0 = act_sent.size();
      for (int i = 0; i < 20; i++) begin
         while (m_q.size() >= DEPTH && guard < 1000) begin cyc(1'b0, 8'h00, 1'b0); guard++; end
         cyc(1'b1, 8'(i), 1'b0);
      end
      drain(600, "burst");
      tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL burst_overflow got %b want 0", bus.overflow); end
      tests++;
      if (act_sent.size() != s0 + 20) begin
         fails++; $display("FAIL burst_count got %0d want 20", act_sent.size() - s0);
      end else begin
         for (int i = 0; i < 20; i++) if (act_sent[s0+i] !== 8'(i)) bad++;
         if (bad != 0) begin fails++; $display("FAIL burst_order got %0d misordered bytes want 0", bad); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp[$];
      logic [7:0] b;
      int s0, bad = 0;
      do_reset();
      auto_done = 1'b0;
      s0 = act_sent.size();
      b = 8'($urandom); exp.push_back(b);
      cyc(1'b1, b, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         if (i < 16) exp.push_back(b);
         cyc(1'b1, b, 1'b0);
         if (i == 15) begin
            tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
         end
      end
      tests++; if (bus.level !== 5'd16)   begin fails++; $display("FAIL ovf_level got %0d want 16", bus.level); end
      tests++; if (bus.full !== 1'b1)     begin fails++; $display("FAIL ovf_full got %b want 1", bus.full); end
      tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
      auto_done = 1'b1; done_delay = 3; done_req++;
      drain(400, "ovf");
      tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
      tests++;
      if (act_sent.size() != s0 + 17) begin
         fails++; $display("FAIL ovf_count got %0d want 17", act_sent.size() - s0);
      end else begin
         for (int i = 0; i < 17; i++) if (act_sent[s0+i] !== exp[i]) bad++;
         if (bad != 0) begin fails++; $display("FAIL ovf_sequence got %0d wrong bytes want 0", bad); end
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] nb;
      int s0, guard = 0;
      do_reset();
      auto_done = 1'b0;
      s0 = act_sent.size();
      cyc(1'b1, 8'($urandom), 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
      tests++; if (bus.level !== 5'd16) begin fails++; $display("FAIL fpp_level_before got %0d want 16", bus.level); end
      auto_done = 1'b1; done_delay = 4; done_req++;
      while (!(!m_busy && m_q.size() != 0) && guard < 50) begin cyc(1'b0, 8'h00, 1'b0); guard++; end
      tests++; if (guard >= 50) begin fails++; $display("FAIL fpp_wait timed out after %0d cycles want pop slot", guard); end
      nb = 8'($urandom);
      cyc(1'b1, nb, 1'b0);
      tests++; if (bus.level !== 5'd16)   begin fails++; $display("FAIL fpp_level got %0d want 16", bus.level); end
      tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL fpp_overflow got %b want 0", bus.overflow); end
      tests++; if (bus.tx_wr !== 1'b1)    begin fails++; $display("FAIL fpp_pop got %b want 1", bus.tx_wr); end
      drain(400, "fpp");
      tests++;
      if (act_sent.size() != s0 + 18) begin
         fails++; $display("FAIL fpp_count got %0d want 18", act_sent.size() - s0);
      end else if (act_sent[s0+17] !== nb) begin
         fails++; $display("FAIL fpp_last got %h want %h", act_sent[s0+17], nb);
      end
   endtask

   task automatic test_flush_busy();
      logic [7:0] nb;
      int s0;
      do_reset();
      auto_done = 1'b0;
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom_range(0, 254)), 1'b0);
      tests++; if (bus.level !== 5'd5) begin fails++; $display("FAIL flush_level_before got %0d want 5", bus.level); end
      s0 = act_sent.size();
      cyc(1'b1, 8'hFF, 1'b1);
      tests++; if (bus.level !== 5'd0)    begin fails++; $display("FAIL flush_level got %0d want 0", bus.level); end
      tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL flush_overflow got %b want 0", bus.overflow); end
      tests++; if (bus.tx_idle !== 1'b0)  begin fails++; $display("FAIL flush_busy_idle got %b want 0", bus.tx_idle); end
      repeat (5) cyc(1'b0, 8'h00, 1'b0);
      done_req++;
      repeat (3) cyc(1'b0, 8'h00, 1'b0);
      tests++; if (bus.tx_idle !== 1'b1)   begin fails++; $display("FAIL flush_idle_after got %b want 1", bus.tx_idle); end
      tests++; if (act_sent.size() != s0)  begin fails++; $display("FAIL flush_no_send got %0d bytes want 0", act_sent.size() - s0); end
      auto_done = 1'b1; done_delay = 2;
      nb = 8'($urandom_range(0, 254));
      cyc(1'b1, nb, 1'b0);
      drain(50, "flush");
      tests++;
      if (act_sent.size() != s0 + 1) begin
         fails++; $display("FAIL flush_resume_count got %0d want 1", act_sent.size() - s0);
      end else if (act_sent[s0] !== nb) begin
         fails++; $display("FAIL flush_resume_data got %h want %h", act_sent[s0], nb);
      end
   endtask

   task automatic test_random();
      int bad = 0, sbad = 0;
      logic p, f;
      do_reset();
      auto_done = 1'b1;
      for (int k = 0; k < 600; k++) begin
         done_delay = $urandom_range(1, 8);
         p = ($urandom_range(0, 2) != 0);
         f = ($urandom_range(0, 49) == 0);
         cyc(p, 8'($urandom), f);
         if (bus.level !== 5'(m_q.size()))                    bad++;
         if (bus.full !== (m_q.size() == DEPTH))              bad++;
         if (bus.empty !== (m_q.size() == 0))                 bad++;
         if (bus.overflow !== m_ovf)                          bad++;
         if (bus.tx_idle !== (m_q.size() == 0 && !m_busy))    bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL rand_status got %0d mismatching samples want 0", bad); end
      drain(1000, "rand");
      tests++;
      if (act_sent.size() != m_sent.size()) begin
         fails++; $display("FAIL rand_count got %0d bytes want %0d", act_sent.size(), m_sent.size());
      end else begin
         foreach (m_sent[i]) if (act_sent[i] !== m_sent[i]) sbad++;
         if (sbad != 0) begin fails++; $display("FAIL rand_stream got %0d wrong bytes want 0", sbad); end
      end
      tests++; if (wr_double != 0) begin fails++; $display("FAIL tx_wr_pulse got %0d double-wide strobes want 0", wr_double); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no completion want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_reset_mid_burst();
      test_burst_wrap();
      test_overflow();
      test_full_push_pop();
      test_flush_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
